// File: rtl/bin2bcd_converter.sv
// Serial 20-bit binary to six-digit BCD converter (shift-add-3 / double dabble).
//
// Ports:
//   clk                    system clock, rising edge
//   rst_n                  asynchronous active-low reset
//   start                  conversion request, only honoured while idle
//   bin_in [19:0]          unsigned binary value, captured on the accepting edge
//   *_out [3:0]            BCD result digits, hundred-thousands down to units
//   overflow               last accepted value exceeded 999999 (digits forced to 9)
//   busy                   conversion in progress
//   done                   one-cycle pulse when new digits are presented
//
// Timing: start accepted at edge k -> 20 shift edges -> outputs and done
// load at edge k+21, done drops at k+22. A start held through the done cycle
// is accepted at edge k+22.
module bin2bcd_converter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [19:0] bin_in,
  output logic [3:0]  hundred_thousands_out,
  output logic [3:0]  ten_thousands_out,
  output logic [3:0]  thousands_out,
  output logic [3:0]  hundreds_out,
  output logic [3:0]  tens_out,
  output logic [3:0]  units_out,
  output logic        overflow,
  output logic        busy,
  output logic        done
);

  localparam logic [19:0] MaxBcd    = 20'd999999;
  localparam logic [4:0]  LastShift = 5'd19;

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e      state_q;
  logic [19:0] shift_q;
  logic [23:0] scratch_q;
  logic [4:0]  count_q;
  // Overflow is decided from the captured value; the shift register no
  // longer holds it once shifting starts, so the compare result is kept.
  logic        ovf_q;
  logic [23:0] scratch_adj;

  // Add 3 to every nibble >= 5 before the shift so it carries correctly.
  always_comb begin
    scratch_adj = scratch_q;
    for (int i = 0; i < 6; i++) begin
      if (scratch_q[4*i +: 4] >= 4'd5) begin
        scratch_adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q               <= StIdle;
      shift_q               <= '0;
      scratch_q             <= '0;
      count_q               <= '0;
      ovf_q                 <= 1'b0;
      hundred_thousands_out <= '0;
      ten_thousands_out     <= '0;
      thousands_out         <= '0;
      hundreds_out          <= '0;
      tens_out              <= '0;
      units_out             <= '0;
      overflow              <= 1'b0;
      busy                  <= 1'b0;
      done                  <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            shift_q   <= bin_in;
            scratch_q <= '0;
            count_q   <= '0;
            ovf_q     <= (bin_in > MaxBcd);
            busy      <= 1'b1;
            state_q   <= StShift;
          end
        end
        StShift: begin
          scratch_q <= {scratch_adj[22:0], shift_q[19]};
          shift_q   <= {shift_q[18:0], 1'b0};
          count_q   <= count_q + 5'd1;
          if (count_q == LastShift) begin
            state_q <= StDone;
          end
        end
        StDone: begin
          if (ovf_q) begin
            hundred_thousands_out <= 4'd9;
            ten_thousands_out     <= 4'd9;
            thousands_out         <= 4'd9;
            hundreds_out          <= 4'd9;
            tens_out              <= 4'd9;
            units_out             <= 4'd9;
          end else begin
            hundred_thousands_out <= scratch_q[23:20];
            ten_thousands_out     <= scratch_q[19:16];
            thousands_out         <= scratch_q[15:12];
            hundreds_out          <= scratch_q[11:8];
            tens_out              <= scratch_q[7:4];
            units_out             <= scratch_q[3:0];
          end
          overflow <= ovf_q;
          done     <= 1'b1;
          busy     <= 1'b0;
          state_q  <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_converter.sv
module tb_bin2bcd_converter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [19:0] bin_in = '0;
  logic [3:0]  d5, d4, d3, d2, d1, d0;
  logic        overflow, busy, done;

  bin2bcd_converter dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .start                 (start),
    .bin_in                (bin_in),
    .hundred_thousands_out (d5),
    .ten_thousands_out     (d4),
    .thousands_out         (d3),
    .hundreds_out          (d2),
    .tens_out              (d1),
    .units_out             (d0),
    .overflow              (overflow),
    .busy                  (busy),
    .done                  (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [23:0] digits;
    logic        ovf;
    int          when;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: pops the scoreboard whenever done is seen.
  logic prev_done = 1'b0;
  always @(negedge clk) begin
    if (prev_done) check("done_one_cycle", {31'd0, done}, 32'd0);
    if (done === 1'b1) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done=1 want no done (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("digits", {8'd0, d5, d4, d3, d2, d1, d0}, {8'd0, e.digits});
        check("overflow", {31'd0, overflow}, {31'd0, e.ovf});
        check("done_cycle", cyc, e.when);
        check("busy_at_done", {31'd0, busy}, 32'd0);
      end
    end
    prev_done = (done === 1'b1);
  end

  // Issue one start pulse; k returns the accepting edge number.
  task automatic issue(input logic [19:0] v, input logic [23:0] d, input logic o,
                       input bit push, output int k);
    @(posedge clk); #1;
    start  = 1'b1;
    bin_in = v;
    k      = cyc + 1;
    if (push) q.push_back('{d, o, k + 21});
    @(posedge clk); #1;
    start  = 1'b0;
    bin_in = 20'($urandom);  // later bin_in changes must not matter
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && q.size() != 0; i++) @(posedge clk);
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: got %0d pending want 0", q.size());
      q.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic check_zero_outputs(input string name);
    check(name, {d5, d4, d3, d2, d1, d0, overflow, busy, done}, 32'd0);
  endtask

  initial begin
    int k;
    repeat (3) @(posedge clk);
    #1;
    check_zero_outputs("reset_state");
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_zero_outputs("idle_after_reset");

    // Basic conversion plus busy/done during conversion.
    issue(20'd123457, 24'h123457, 1'b0, 1'b1, k);
    check("busy_after_accept", {31'd0, busy}, 32'd1);
    check("done_low_mid", {31'd0, done}, 32'd0);
    drain();

    issue(20'd0,       24'h000000, 1'b0, 1'b1, k); drain();
    issue(20'd999999,  24'h999999, 1'b0, 1'b1, k); drain();
    issue(20'd1000000, 24'h999999, 1'b1, 1'b1, k); drain();
    issue(20'd1048575, 24'h999999, 1'b1, 1'b1, k); drain();
    issue(20'd5,       24'h000005, 1'b0, 1'b1, k); drain();
    issue(20'd90817,   24'h090817, 1'b0, 1'b1, k); drain();

    // Start while busy is ignored; busy must stay high throughout.
    @(posedge clk); #1;
    start  = 1'b1;
    bin_in = 20'd42;
    k      = cyc + 1;
    q.push_back('{24'h000042, 1'b0, k + 21});
    for (int i = 0; i <= 20; i++) begin
      @(posedge clk); #1;
      start  = (i == 5);
      bin_in = (i == 5) ? 20'd777 : 20'd42;
      check("busy_hold", {31'd0, busy}, 32'd1);
    end
    start = 1'b0;
    drain();

    // Reset mid-conversion: immediate clear, no done.
    issue(20'd999, 24'h0, 1'b0, 1'b0, k);
    repeat (9) @(posedge clk);
    #1;
    check("pre_reset_tens", {28'd0, d1}, 32'd4);
    rst_n = 1'b0;
    #1;
    check_zero_outputs("async_reset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    check("no_done_after_abort", {31'd0, busy}, 32'd0);
    issue(20'd654321, 24'h654321, 1'b0, 1'b1, k); drain();

    // Back-to-back with start held: second accepted on the done cycle.
    @(posedge clk); #1;
    start  = 1'b1;
    bin_in = 20'd100;
    k      = cyc + 1;
    q.push_back('{24'h000100, 1'b0, k + 21});
    q.push_back('{24'h000200, 1'b0, k + 43});
    @(posedge clk); #1;
    bin_in = 20'd200;
    repeat (22) @(posedge clk);
    #1;
    start = 1'b0;
    check("b2b_busy", {31'd0, busy}, 32'd1);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bin2bcd_converter.md
BIN2BCD_CONVERTER -- requirements
Module: bin2bcd_converter

Interface
REQ-001 The block SHALL have no parameters; the binary width is fixed at 20 bits and the BCD width at six digits.
REQ-002 clk  input  1  single system clock; all state changes on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 start  input  1  conversion request, sampled only in IDLE.
REQ-005 bin_in  input  20  unsigned binary count, sampled on the edge that accepts start.
REQ-006 hundred_thousands_out, ten_thousands_out, thousands_out, hundreds_out, tens_out, units_out  output  4 each  BCD result digits, in order MSD to LSD.
REQ-007 overflow  output  1  high when the last accepted bin_in exceeded 999999.
REQ-008 busy  output  1  high while a conversion is in progress (SHIFT or DONE state).
REQ-009 done  output  1  one-cycle pulse marking new valid digits.

Function
REQ-010 The block SHALL be a serial shift-add-3 (double-dabble) converter with the states IDLE, SHIFT and DONE.
REQ-011 IDLE: a rising edge with start=1 SHALL latch bin_in into a 20-bit shift register, clear the 24-bit BCD scratch register, clear the iteration counter, and go to SHIFT; start=0 keeps the block in IDLE.
REQ-012 SHIFT: each edge SHALL first add 3 to every scratch nibble that is >=5, then shift {scratch, shift register} left by one bit, then increment the counter.
REQ-013 After the 20th SHIFT edge the state SHALL go to DONE; the counter is 5 bits wide and is not used beyond 20.
REQ-014 DONE: the next edge SHALL load all six output digits and overflow, assert done for exactly one cycle, and return to IDLE.
REQ-015 Latency: start accepted at edge k SHALL give done high from edge k+21 to edge k+22.
REQ-016 busy SHALL be high from edge k to edge k+21 and SHALL fall in the same edge that done rises.
REQ-017 A start asserted while busy=1 SHALL be ignored, with no queuing and no effect on the conversion in progress.
REQ-018 A start asserted in the cycle done=1 SHALL be accepted at that edge, because the state is already IDLE.
REQ-019 Overflow: when the latched value is >999999, every output digit SHALL be 9 and overflow SHALL be 1; otherwise overflow SHALL be 0.
REQ-020 The overflow compare SHALL use the latched value, not the live bin_in.
REQ-021 The output digits and overflow SHALL hold their last values between conversions, and bin_in changes after acceptance SHALL have no effect.
REQ-022 Each output digit SHALL never exceed 9.

Reset
REQ-023 rst_n=0 SHALL immediately force IDLE, clear all six digits and overflow to 0, clear busy and done to 0, and clear the counter and scratch register.
REQ-024 Reset asserted mid-conversion SHALL abort the conversion with no done pulse; the first start after release SHALL be processed normally.

Verification
REQ-025 bin_in=123457, start pulsed for one cycle -> digits 1,2,3,4,5,7, overflow=0, done exactly 21 cycles after the accepting edge, done high for one cycle.
REQ-026 bin_in=0 -> all digits 0, overflow=0; bin_in=999999 -> all digits 9, overflow=0.
REQ-027 bin_in=1000000 and bin_in=1048575 -> all digits 9, overflow=1; a following bin_in=5 -> digits 0,0,0,0,0,5, overflow=0.
REQ-028 start with bin_in=42, then start with bin_in=777 at cycle 5 of the conversion -> a single done, result 42, busy never drops early.
REQ-029 rst_n low at cycle 10 of a conversion -> outputs 0 asynchronously and no done; start with bin_in=654321 after release -> digits 6,5,4,3,2,1.
REQ-030 Back-to-back: start held high continuously with bin_in=100 then bin_in=200 -> the second conversion is accepted on the done edge, with done pulses exactly 22 cycles apart.
